// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - write-through write buffer with read forwarding between dcache and data RAM
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wd,
  output logic                   cpu_stall,
  output logic [31:0]            cpu_rd,
  output logic                   cpu_rvalid,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wd,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rd,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PW-1:0]   head, tail;
  logic            pending;
  logic [AW-1:0]   rd_addr;

  logic [AW-1:0]   word_addr;
  logic            unused_addr_bits;
  logic            full, re_req, enq, deq, launch, rd_done;
  logic            hit;
  logic [31:0]     hit_data;

  // Byte offset bits never matter for word accesses.
  assign word_addr        = cpu_addr[AW+1:2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // A simultaneous write and read is handled as the write alone.
  assign re_req    = cpu_re && !cpu_we;
  assign full      = (count == CW'(DEPTH));
  assign enq       = cpu_we && !full;
  assign launch    = re_req && !pending && !cpu_rvalid;
  assign cpu_stall = (cpu_we && full) || (re_req && !cpu_rvalid);

  // Forwarding search: walk oldest to youngest so the last hit is the youngest write.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (addr_q[head + PW'(i)] == word_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[head + PW'(i)];
      end
    end
  end

  // Buffer storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= word_addr;
      data_q[tail] <= cpu_wd;
    end
  end

  // Memory-side FSM: next state and bus outputs, bus idles at zero.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    deq       = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pending)
          state_nxt = RD;
        else if (count != '0)
          state_nxt = WR;
      end
      WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q[head];
        mem_wd   = data_q[head];
        if (mem_gnt) begin
          deq       = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr;
        if (mem_gnt)
          state_nxt = RWAIT;
      end
      RWAIT: begin
        if (mem_rvalid) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, queue bookkeeping and read completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pending    <= 1'b0;
      rd_addr    <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rd     <= '0;
    end else begin
      state      <= state_nxt;
      cpu_rvalid <= 1'b0;
      if (enq)
        tail <= tail + 1'b1;
      if (deq)
        head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_done) begin
        cpu_rd     <= mem_rd;
        cpu_rvalid <= 1'b1;
        pending    <= 1'b0;
      end else if (launch) begin
        if (hit) begin
          cpu_rd     <= hit_data;
          cpu_rvalid <= 1'b1;
        end else begin
          pending <= 1'b1;
          rd_addr <= word_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - scoreboard testbench for dmem_write_buffer
module tb_dmem_write_buffer;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wd;
  } mem_txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_addr, cpu_wd;
  logic        cpu_stall;
  logic [31:0] cpu_rd;
  logic        cpu_rvalid;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rd;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          forbid_read = 1'b0;
  mem_txn_t    exp_mem[$];
  logic [31:0] exp_rd[$];
  mem_txn_t    mon_t;
  logic [31:0] mon_d;

  dmem_write_buffer #(.DEPTH(4), .AW(30)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_stall(cpu_stall), .cpu_rd(cpu_rd), .cpu_rvalid(cpu_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rd(mem_rd),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic mem_txn_t txn(input logic we, input logic [29:0] a, input logic [31:0] d);
    mem_txn_t t;
    t.we = we; t.addr = a; t.wd = d;
    return t;
  endfunction

  // Negedge monitor: completed handshakes and read returns against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req && mem_gnt) begin
        n_checks++;
        if (exp_mem.size() == 0) begin
          n_errors++;
          $display("FAIL mem_handshake: got we=%0b addr=%h wd=%h, required no transaction", mem_we, mem_addr, mem_wd);
        end else begin
          mon_t = exp_mem.pop_front();
          if (mem_we !== mon_t.we || mem_addr !== mon_t.addr || (mon_t.we && mem_wd !== mon_t.wd)) begin
            n_errors++;
            $display("FAIL mem_handshake: got we=%0b addr=%h wd=%h, required we=%0b addr=%h wd=%h",
                     mem_we, mem_addr, mem_wd, mon_t.we, mon_t.addr, mon_t.wd);
          end
        end
      end
      if (cpu_rvalid) begin
        n_checks++;
        if (exp_rd.size() == 0) begin
          n_errors++;
          $display("FAIL cpu_read: got rvalid with rd=%h, required no read return", cpu_rd);
        end else begin
          mon_d = exp_rd.pop_front();
          if (cpu_rd !== mon_d) begin
            n_errors++;
            $display("FAIL cpu_read: got rd=%h, required %h", cpu_rd, mon_d);
          end
        end
      end
      if (forbid_read && mem_req) begin
        n_checks++;
        if (mem_we !== 1'b1) begin
          n_errors++;
          $display("FAIL no_mem_read: got mem_we=%0b with mem_req, required 1", mem_we);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rd = 0; forbid_read = 0;
    reset = 1;
    step();
    step();
    reset = 0;
    #1;
  endtask

  task automatic wait_count_zero(input string name);
    bit ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (count == 3'd0) begin ok = 1; break; end
      step();
      #1;
    end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL %s: got count=%0d after timeout, required 0", name, count); end
  endtask

  // Memory responder: returns read data two cycles after the read grant.
  task automatic mem_read_return(input logic [31:0] data, output bit got, output bit stalled);
    int wait_n;
    wait_n = -1;
    got = 0;
    stalled = 1;
    for (int c = 0; c < 30; c++) begin
      step();
      mem_rvalid = 0;
      if (wait_n == 0) begin mem_rvalid = 1; mem_rd = data; end
      if (wait_n >= 0) wait_n--;
      #1;
      if (cpu_rvalid) begin got = 1; break; end
      if (!cpu_stall) stalled = 0;
      if (mem_req && !mem_we && mem_gnt) wait_n = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d, required 0", count); end
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 30'h0 || mem_wd !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mem_bus: got req=%0b we=%0b addr=%h wd=%h, required all 0", mem_req, mem_we, mem_addr, mem_wd);
    end
    n_checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rd !== 32'h0) begin
      n_errors++; $display("FAIL reset_cpu_rd: got rvalid=%0b rd=%h, required 0/0", cpu_rvalid, cpu_rd);
    end
    n_checks++;
    if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b, required 0", cpu_stall); end
  endtask

  task automatic test_single_write();
    bit ok = 0;
    mem_gnt = 1;
    step();
    cpu_we = 1; cpu_addr = 32'h10; cpu_wd = 32'hDEADBEEF;
    exp_mem.push_back(txn(1'b1, 30'h4, 32'hDEADBEEF));
    #1;
    n_checks++;
    if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL single_stall: got %0b, required 0", cpu_stall); end
    step();
    cpu_we = 0;
    #1;
    n_checks++;
    if (count !== 3'd1) begin n_errors++; $display("FAIL single_count1: got %0d, required 1", count); end
    for (int c = 0; c < 8; c++) begin
      if (mem_req) begin ok = 1; break; end
      step();
      #1;
    end
    n_checks++;
    if (!ok || mem_we !== 1'b1 || mem_addr !== 30'h4 || mem_wd !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL single_req: got req=%0b we=%0b addr=%h wd=%h, required 1/1/4/deadbeef", mem_req, mem_we, mem_addr, mem_wd);
    end
    step();
    #1;
    n_checks++;
    if (count !== 3'd0) begin n_errors++; $display("FAIL single_count0: got %0d, required 0", count); end
    mem_gnt = 0;
  endtask

  task automatic test_full();
    mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      cpu_we = 1; cpu_addr = 32'h100 + 32'(4 * i); cpu_wd = 32'hA0 + 32'(i);
      exp_mem.push_back(txn(1'b1, 30'h40 + 30'(i), 32'hA0 + 32'(i)));
      #1;
      n_checks++;
      if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL full_accept%0d: got stall=%0b, required 0", i, cpu_stall); end
    end
    step();
    cpu_addr = 32'h110; cpu_wd = 32'hA4;
    #1;
    n_checks++;
    if (count !== 3'd4 || cpu_stall !== 1'b1) begin
      n_errors++; $display("FAIL full_stall: got count=%0d stall=%0b, required 4/1", count, cpu_stall);
    end
    step();
    #1;
    mem_gnt = 1;
    #1;
    n_checks++;
    if (cpu_stall !== 1'b1) begin n_errors++; $display("FAIL full_no_passthru: got stall=%0b, required 1", cpu_stall); end
    step();
    mem_gnt = 0;
    exp_mem.push_back(txn(1'b1, 30'h44, 32'hA4));
    #1;
    n_checks++;
    if (count !== 3'd3 || cpu_stall !== 1'b0) begin
      n_errors++; $display("FAIL full_after_deq: got count=%0d stall=%0b, required 3/0", count, cpu_stall);
    end
    step();
    cpu_we = 0;
    #1;
    n_checks++;
    if (count !== 3'd4) begin n_errors++; $display("FAIL full_refill: got count=%0d, required 4", count); end
    mem_gnt = 1;
    wait_count_zero("full_drain");
    mem_gnt = 0;
  endtask

  task automatic test_forward();
    forbid_read = 1;
    mem_gnt = 0;
    step();
    cpu_we = 1; cpu_addr = 32'h20; cpu_wd = 32'h11;
    exp_mem.push_back(txn(1'b1, 30'h8, 32'h11));
    #1;
    step();
    cpu_wd = 32'h22;
    exp_mem.push_back(txn(1'b1, 30'h8, 32'h22));
    #1;
    step();
    cpu_we = 0; cpu_re = 1; cpu_addr = 32'h20;
    exp_rd.push_back(32'h22);
    #1;
    n_checks++;
    if (cpu_stall !== 1'b1) begin n_errors++; $display("FAIL fwd_stall: got %0b, required 1", cpu_stall); end
    step();
    #1;
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rd !== 32'h22 || cpu_stall !== 1'b0) begin
      n_errors++; $display("FAIL fwd_data: got rvalid=%0b rd=%h stall=%0b, required 1/22/0", cpu_rvalid, cpu_rd, cpu_stall);
    end
    cpu_re = 0;
    step();
    #1;
    n_checks++;
    if (cpu_rvalid !== 1'b0 || count !== 3'd2) begin
      n_errors++; $display("FAIL fwd_after: got rvalid=%0b count=%0d, required 0/2", cpu_rvalid, count);
    end
    mem_gnt = 1;
    wait_count_zero("fwd_drain");
    mem_gnt = 0;
    forbid_read = 0;
  endtask

  task automatic test_read_miss();
    bit got, stalled;
    mem_gnt = 1;
    step();
    cpu_re = 1; cpu_addr = 32'h40;
    exp_mem.push_back(txn(1'b0, 30'h10, 32'h0));
    exp_rd.push_back(32'hCAFE0001);
    #1;
    n_checks++;
    if (cpu_stall !== 1'b1) begin n_errors++; $display("FAIL miss_stall0: got %0b, required 1", cpu_stall); end
    mem_read_return(32'hCAFE0001, got, stalled);
    n_checks++;
    if (!got || !stalled) begin n_errors++; $display("FAIL miss_return: got rvalid_seen=%0b stalled_throughout=%0b, required 1/1", got, stalled); end
    n_checks++;
    if (cpu_rd !== 32'hCAFE0001 || cpu_stall !== 1'b0) begin
      n_errors++; $display("FAIL miss_data: got rd=%h stall=%0b, required cafe0001/0", cpu_rd, cpu_stall);
    end
    cpu_re = 0;
    mem_gnt = 0;
    step();
    #1;
  endtask

  task automatic test_read_priority();
    bit got, stalled;
    bit ok = 0;
    mem_gnt = 0;
    step();
    cpu_we = 1; cpu_addr = 32'h80; cpu_wd = 32'h1;
    exp_mem.push_back(txn(1'b1, 30'h20, 32'h1));
    #1;
    step();
    cpu_addr = 32'h84; cpu_wd = 32'h2;
    #1;
    step();
    cpu_we = 0;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (mem_req) begin ok = 1; break; end
      step();
      #1;
    end
    n_checks++;
    if (!ok || mem_we !== 1'b1 || mem_addr !== 30'h20) begin
      n_errors++; $display("FAIL prio_wr: got req=%0b we=%0b addr=%h, required 1/1/20", mem_req, mem_we, mem_addr);
    end
    step();
    cpu_re = 1; cpu_addr = 32'h44;
    exp_mem.push_back(txn(1'b0, 30'h11, 32'h0));
    exp_mem.push_back(txn(1'b1, 30'h21, 32'h2));
    exp_rd.push_back(32'h5A5A0044);
    #1;
    step();
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'h20 || mem_wd !== 32'h1) begin
      n_errors++; $display("FAIL prio_hold: got req=%0b we=%0b addr=%h wd=%h, required 1/1/20/1", mem_req, mem_we, mem_addr, mem_wd);
    end
    mem_gnt = 1;
    mem_read_return(32'h5A5A0044, got, stalled);
    n_checks++;
    if (!got || !stalled || cpu_rd !== 32'h5A5A0044) begin
      n_errors++; $display("FAIL prio_return: got seen=%0b stalled=%0b rd=%h, required 1/1/5a5a0044", got, stalled, cpu_rd);
    end
    n_checks++;
    if (count !== 3'd1) begin n_errors++; $display("FAIL prio_queued: got count=%0d, required 1", count); end
    cpu_re = 0;
    wait_count_zero("prio_drain");
    mem_gnt = 0;
  endtask

  task automatic test_reset_mid_read();
    bit ok = 0;
    mem_gnt = 1;
    step();
    cpu_re = 1; cpu_addr = 32'h60;
    exp_mem.push_back(txn(1'b0, 30'h18, 32'h0));
    #1;
    for (int c = 0; c < 10; c++) begin
      if (mem_req && !mem_we && mem_gnt) begin ok = 1; break; end
      step();
      #1;
    end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL rst_rd_grant: got no read request, required one"); end
    step();
    reset = 1; cpu_re = 0; mem_gnt = 0;
    #1;
    step();
    reset = 0; mem_rvalid = 1; mem_rd = 32'hBAD0BAD0;
    #1;
    step();
    mem_rvalid = 0;
    #1;
    n_checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rd !== 32'h0) begin
      n_errors++; $display("FAIL rst_late_return: got rvalid=%0b rd=%h, required 0/0", cpu_rvalid, cpu_rd);
    end
    n_checks++;
    if (count !== 3'd0 || mem_req !== 1'b0) begin
      n_errors++; $display("FAIL rst_idle: got count=%0d req=%0b, required 0/0", count, mem_req);
    end
    step();
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_errors++; $display("FAIL rst_no_pending: got req=%0b, required 0", mem_req); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_forward();
    test_read_miss();
    test_read_priority();
    test_reset_mid_read();
    step();
    n_checks++;
    if (exp_mem.size() != 0 || exp_rd.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %0d mem and %0d read entries left, required 0/0", exp_mem.size(), exp_rd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
